// File: rtl/present_pkg.sv
// ============================================================================
//  Module      : present_pkg
//  Description : Shared constants, S-box table and FSM state type for the
//                iterative PRESENT-80 encryption engine.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package present_pkg;

    localparam int SIZE       = 64;
    localparam int KEY_BITS   = 80;
    localparam int NUM_ROUNDS = 31;

    // Nibble n of this word is S(n): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Single 4-bit S-box lookup
    function automatic logic [3:0] sbox4(input logic [3:0] nib);
        return SBOX_TABLE[{nib, 2'b00} +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/present_player.sv
// ============================================================================
//  Module      : present_player
//  Description : PRESENT 64-bit bit permutation. Bit i moves to i*16 mod 63,
//                bit 63 stays in place.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module present_player (
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    genvar i;
    generate
        for (i = 0; i < 63; i++) begin : g_bit
            assign data_o[(i*16) % 63] = data_i[i];
        end
    endgenerate

    assign data_o[63] = data_i[63];

endmodule

`default_nettype wire

// File: rtl/present_sbox_layer.sv
// ============================================================================
//  Module      : present_sbox_layer
//  Description : NIBBLES parallel 4-bit PRESENT S-box lookups, combinational.
//                NIBBLES=16 covers the data path, NIBBLES=1 the key schedule.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module present_sbox_layer
    import present_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic [4*NIBBLES-1:0] data_i,
    output logic [4*NIBBLES-1:0] data_o
);

    genvar i;
    generate
        for (i = 0; i < NIBBLES; i++) begin : g_nib
            assign data_o[4*i +: 4] = sbox4(data_i[4*i +: 4]);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/present_round_ctrl.sv
// ============================================================================
//  Module      : present_round_ctrl
//  Description : Iterative PRESENT-80 encryption controller. One full round
//                (addRoundKey, sBoxLayer, pLayer) plus key-schedule step per
//                clock, valid/ready handshake on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module present_round_ctrl
    import present_pkg::*;
#(
    parameter int ROUNDS = NUM_ROUNDS   // 1..31, counter is 5 bits
) (
    input  logic                clk,
    input  logic                reset,       // asynchronous, active-low
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     plaintext,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE-1:0]     ciphertext,
    output logic                busy,
    output logic [4:0]          round
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    state_e              fsm_q;
    logic [SIZE-1:0]     state_q;
    logic [KEY_BITS-1:0] key_q;
    logic [4:0]          rcnt_q;
    logic [SIZE-1:0]     ct_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [SIZE-1:0]     round_in;
    logic [SIZE-1:0]     sbox_out;
    logic [SIZE-1:0]     state_d;
    logic [KEY_BITS-1:0] key_rot;
    logic [3:0]          key_sb;
    logic [KEY_BITS-1:0] key_d;

    // Round datapath: whiten with the top 64 key bits, substitute, permute
    assign round_in = state_q ^ key_q[79:16];

    present_sbox_layer #(.NIBBLES(16)) u_sbox (
        .data_i (round_in),
        .data_o (sbox_out)
    );

    present_player u_player (
        .data_i (sbox_out),
        .data_o (state_d)
    );

    // Key schedule: rotate left 61, S-box the top nibble, fold in the counter
    assign key_rot = {key_q[18:0], key_q[79:19]};

    present_sbox_layer #(.NIBBLES(1)) u_key_sbox (
        .data_i (key_rot[79:76]),
        .data_o (key_sb)
    );

    assign key_d = {key_sb, key_rot[75:20], key_rot[19:15] ^ rcnt_q, key_rot[14:0]};

    // Control FSM with registered handshake/status outputs and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            rcnt_q      <= 5'd0;
            ct_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        state_q    <= plaintext;
                        key_q      <= key;
                        rcnt_q     <= 5'd1;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        fsm_q      <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    key_q   <= key_d;
                    if (rcnt_q == LAST_ROUND) begin
                        // Final whitening uses the key produced in this same step
                        ct_q        <= state_d ^ key_d[79:16];
                        rcnt_q      <= 5'd0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        rcnt_q <= rcnt_q + 5'd1;
                    end
                end
                DONE: begin
                    // No bypass: the next block can only be taken from IDLE
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;
    assign busy       = busy_q;
    assign round      = rcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_present_round_ctrl.sv
// ============================================================================
//  Module      : tb_present_round_ctrl
//  Description : Directed self-checking bench for present_round_ctrl using the
//                published PRESENT-80 test vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_present_round_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;
    logic        busy;
    logic [4:0]  round;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
    localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
    localparam logic [63:0] PT_F  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [79:0] K_F   = 80'hFFFFFFFFFFFFFFFFFFFF;

    present_round_ctrl #(.ROUNDS(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and return right after the accept edge
    task automatic start_block(input logic [63:0] pt, input logic [79:0] k);
        int g = 0;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid, bounded
    task automatic wait_out(output int edges, output bit timed_out);
        edges = 0;
        while (!out_valid && edges < 200) begin
            tick();
            edges++;
        end
        timed_out = !out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got in_ready/out_valid/busy=%b expected 000", {in_ready, out_valid, busy});
        end
        n_cmp++;
        if (round !== 5'd0 || ciphertext !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got round=%0d ct=%h expected 0/0", round, ciphertext);
        end
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held_ready: got %b expected 0", in_ready);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || round !== 5'd0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b busy=%b round=%0d expected 1/0/0", in_ready, busy, round);
        end
    endtask

    task automatic test_zero_vector();
        int  lat;
        bit  to;
        start_block(64'd0, 80'd0);
        wait_out(lat, to);
        n_cmp++;
        if (to || lat != 31) begin
            n_err++;
            $display("FAIL zero_latency: got %0d edges (timeout=%0b) expected 31", lat, to);
        end
        n_cmp++;
        if (ciphertext !== CT_00) begin
            n_err++;
            $display("FAIL zero_ct: got %h expected %h", ciphertext, CT_00);
        end
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || round !== 5'd0) begin
            n_err++;
            $display("FAIL done_flags: got busy=%b in_ready=%b round=%0d expected 0/0/0", busy, in_ready, round);
        end
        release_out();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL done_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_key_ones();
        int  lat;
        bit  to;
        start_block(64'd0, K_F);
        wait_out(lat, to);
        n_cmp++;
        if (to || ciphertext !== CT_0F) begin
            n_err++;
            $display("FAIL keyff_ct: got %h (timeout=%0b) expected %h", ciphertext, to, CT_0F);
        end
        release_out();
    endtask

    task automatic test_hold();
        int  lat;
        bit  to;
        int  bad_v = 0, bad_c = 0, bad_r = 0;
        start_block(PT_F, 80'd0);
        wait_out(lat, to);
        n_cmp++;
        if (to || ciphertext !== CT_F0) begin
            n_err++;
            $display("FAIL hold_ct: got %h (timeout=%0b) expected %h", ciphertext, to, CT_F0);
        end
        in_valid  = 1'b1;
        plaintext = 64'h0123456789ABCDEF;
        key       = 80'h1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1) bad_v++;
            if (ciphertext !== CT_F0) bad_c++;
            if (in_ready !== 1'b0) bad_r++;
        end
        n_cmp++;
        if (bad_v != 0 || bad_c != 0 || bad_r != 0) begin
            n_err++;
            $display("FAIL hold_stable: got valid/ct/ready bad cycles=%0d/%0d/%0d expected 0/0/0", bad_v, bad_c, bad_r);
        end
        in_valid = 1'b0;
        release_out();
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_no_accept: got busy=%b in_ready=%b out_valid=%b expected 0/1/0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_run_sequence();
        int bad_round = 0, bad_busy = 0;
        start_block(PT_F, K_F);
        for (int i = 1; i <= 31; i++) begin
            if (round !== 5'(i)) bad_round++;
            if (busy !== 1'b1 || out_valid !== 1'b0) bad_busy++;
            tick();
            plaintext = {$urandom, $urandom};
            key       = {16'($urandom), $urandom, $urandom};
        end
        n_cmp++;
        if (bad_round != 0) begin
            n_err++;
            $display("FAIL round_seq: got %0d wrong cycles expected 0", bad_round);
        end
        n_cmp++;
        if (bad_busy != 0) begin
            n_err++;
            $display("FAIL run_busy: got %0d wrong cycles expected 0", bad_busy);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || ciphertext !== CT_FF) begin
            n_err++;
            $display("FAIL ff_ct: got valid=%b ct=%h expected 1/%h", out_valid, ciphertext, CT_FF);
        end
        release_out();
    endtask

    task automatic test_abort();
        int  g = 0;
        int  spurious = 0;
        int  lat;
        bit  to;
        start_block(64'd0, 80'd0);
        while (round !== 5'd15 && g < 40) begin
            tick();
            g++;
        end
        reset = 1'b0;
        #2;
        n_cmp++;
        if (round !== 5'd0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_clear: got round=%0d busy=%b out_valid=%b in_ready=%b expected 0/0/0/0", round, busy, out_valid, in_ready);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) spurious++;
        end
        n_cmp++;
        if (spurious != 0) begin
            n_err++;
            $display("FAIL abort_spurious: got %0d out_valid cycles expected 0", spurious);
        end
        start_block(64'd0, 80'd0);
        wait_out(lat, to);
        n_cmp++;
        if (to || lat != 31 || ciphertext !== CT_00) begin
            n_err++;
            $display("FAIL abort_rerun: got lat=%0d ct=%h expected 31/%h", lat, ciphertext, CT_00);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [63:0] pt_v [3];
        logic [79:0] k_v  [3];
        logic [63:0] ct_v [3];
        int acc_cyc [3];
        int na = 0, no = 0, bad_ct = 0;
        pt_v[0] = 64'd0; k_v[0] = 80'd0; ct_v[0] = CT_00;
        pt_v[1] = PT_F;  k_v[1] = 80'd0; ct_v[1] = CT_F0;
        pt_v[2] = 64'd0; k_v[2] = K_F;   ct_v[2] = CT_0F;
        plaintext = pt_v[0];
        key       = k_v[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && no < 3; cyc++) begin
            if (in_ready && na < 3) begin
                acc_cyc[na] = cyc;
                na++;
            end
            if (out_valid) begin
                if (ciphertext !== ct_v[no]) begin
                    bad_ct++;
                    $display("FAIL b2b_ct%0d: got %h expected %h", no, ciphertext, ct_v[no]);
                end
                no++;
            end
            tick();
            if (na < 3) begin
                plaintext = pt_v[na];
                key       = k_v[na];
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if (no != 3 || bad_ct != 0) begin
            n_err++;
            $display("FAIL b2b_results: got %0d outputs %0d wrong expected 3 outputs 0 wrong", no, bad_ct);
        end
        n_cmp++;
        if (na != 3 || acc_cyc[1] - acc_cyc[0] != 33 || acc_cyc[2] - acc_cyc[1] != 33) begin
            n_err++;
            $display("FAIL b2b_spacing: got accepts=%0d gaps=%0d/%0d expected 3 accepts gaps 33/33",
                     na, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_key_ones();
        test_hold();
        test_run_sequence();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
